// File: rtl/dmem_access_ctrl.sv
// Memory-stage data-memory access sequencer for the RV32 pipeline: drives a req/gnt/rvalid bus,
// stalls the pipeline while an access is outstanding, aligns load/store data and flags errors.
module dmem_access_ctrl #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned TIMEOUT    = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  MemReadM,
    input  logic                  MemWriteM,
    input  logic [1:0]            SizeM,
    input  logic [DATA_WIDTH-1:0] ALUResultM,
    input  logic [DATA_WIDTH-1:0] WriteDataM,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] mem_addr,
    output logic [3:0]            mem_be,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_gnt,
    input  logic                  mem_rvalid,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [DATA_WIDTH-1:0] ReadDataM,
    output logic                  StallM,
    output logic                  BusErrM,
    output logic                  BusErrSticky
);

    localparam int unsigned CntW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StWaitGnt, StWaitRd, StDone} state_e;

    state_e                  state_q, state_d;
    logic [CntW-1:0]         cnt_q, cnt_d;
    logic [1:0]              offset_q, offset_d;
    logic [1:0]              size_q, size_d;
    logic                    we_q, we_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic                    sticky_q, sticky_d;

    logic                    acc;
    logic                    misaligned;
    logic                    timeout_hit;
    logic                    req, stall, err;
    logic [DATA_WIDTH-1:0]   rd_shifted, rd_data;

    assign acc = MemReadM | MemWriteM;
    assign misaligned = (SizeM == 2'b11) ||
                        ((SizeM == 2'b01) && ALUResultM[0]) ||
                        ((SizeM == 2'b10) && (ALUResultM[1:0] != 2'b00));
    assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CntLast);

    // The pipeline is frozen while waiting, so address and store data stay stable on their own.
    assign mem_addr  = {ALUResultM[DATA_WIDTH-1:2], 2'b00};
    assign mem_wdata = WriteDataM << {ALUResultM[1:0], 3'b000};
    assign mem_we    = (state_q == StIdle) ? MemWriteM : we_q;

    always_comb begin
        unique case (SizeM)
            2'b00:   mem_be = 4'b0001 << ALUResultM[1:0];
            2'b01:   mem_be = 4'b0011 << ALUResultM[1:0];
            default: mem_be = 4'b1111;
        endcase
    end

    always_comb begin
        rd_shifted = rdata_q >> {offset_q, 3'b000};
        unique case (size_q)
            2'b00:   rd_data = {24'b0, rd_shifted[7:0]};
            2'b01:   rd_data = {16'b0, rd_shifted[15:0]};
            default: rd_data = rd_shifted;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        offset_d = offset_q;
        size_d   = size_q;
        we_d     = we_q;
        rdata_d  = rdata_q;
        req      = 1'b0;
        stall    = 1'b0;
        err      = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (acc && misaligned) begin
                    err = 1'b1;
                end else if (acc) begin
                    req      = 1'b1;
                    stall    = !(MemWriteM && mem_gnt);
                    offset_d = ALUResultM[1:0];
                    size_d   = SizeM;
                    we_d     = MemWriteM;
                    cnt_d    = '0;
                    if (MemWriteM) begin
                        state_d = mem_gnt ? StIdle : StWaitGnt;
                    end else begin
                        state_d = mem_gnt ? StWaitRd : StWaitGnt;
                    end
                end
            end
            StWaitGnt: begin
                req   = 1'b1;
                stall = 1'b1;
                if (mem_gnt) begin
                    state_d = we_q ? StDone : StWaitRd;
                    cnt_d   = '0;
                end else if (timeout_hit) begin
                    err     = 1'b1;
                    rdata_d = '0;
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StWaitRd: begin
                stall = 1'b1;
                if (mem_rvalid) begin
                    rdata_d = mem_rdata;
                    state_d = StDone;
                end else if (timeout_hit) begin
                    err     = 1'b1;
                    rdata_d = '0;
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Async reset only clears state; outputs are gated so nothing leaks while reset is held.
    assign mem_req      = req & ~reset;
    assign StallM       = stall & ~reset;
    assign BusErrM      = err & ~reset;
    assign ReadDataM    = (state_q == StDone && !reset) ? rd_data : '0;
    assign BusErrSticky = sticky_q;
    assign sticky_d     = sticky_q | BusErrM;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            offset_q <= 2'b00;
            size_q   <= 2'b00;
            we_q     <= 1'b0;
            rdata_q  <= '0;
            sticky_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            offset_q <= offset_d;
            size_q   <= size_d;
            we_q     <= we_d;
            rdata_q  <= rdata_d;
            sticky_q <= sticky_d;
        end
    end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Bench for dmem_access_ctrl: single-cycle vector table, directed multi-cycle sequences and a
// randomized run checked against a transaction-level reference model.
module tb_dmem_access_ctrl;

    localparam int unsigned TO = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        MemReadM, MemWriteM;
    logic [1:0]  SizeM;
    logic [31:0] ALUResultM, WriteDataM;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_gnt, mem_rvalid;
    logic [31:0] mem_rdata;
    logic [31:0] ReadDataM;
    logic        StallM, BusErrM, BusErrSticky;

    int tests = 0;
    int fails = 0;

    dmem_access_ctrl #(.DATA_WIDTH(32), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .MemReadM(MemReadM), .MemWriteM(MemWriteM), .SizeM(SizeM),
        .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata), .ReadDataM(ReadDataM), .StallM(StallM),
        .BusErrM(BusErrM), .BusErrSticky(BusErrSticky)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_in();
        MemReadM = 0; MemWriteM = 0; SizeM = 0; ALUResultM = 0; WriteDataM = 0;
        mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
    endtask

    task automatic set_acc(input logic rd, input logic wr, input logic [1:0] sz,
                           input logic [31:0] a, input logic [31:0] wd);
        MemReadM = rd; MemWriteM = wr; SizeM = sz; ALUResultM = a; WriteDataM = wd;
    endtask

    // ---------------- reference model (access-level view of the bus) ----------------
    function automatic logic [31:0] extract(input logic [31:0] w, input int off, input int sz);
        logic [31:0] s;
        s = w >> (8 * off);
        if (sz == 0) return s & 32'h0000_00FF;
        if (sz == 1) return s & 32'h0000_FFFF;
        return s;
    endfunction

    function automatic bit is_misaligned(input int sz, input logic [31:0] a);
        return (sz == 3) || (sz == 1 && (a % 2) != 0) || (sz == 2 && (a % 4) != 0);
    endfunction

    int          m_pend;    // 0 nothing outstanding, 1 awaiting grant, 2 awaiting read data
    bit          m_done;    // response cycle pending
    bit          m_wr;
    int          m_off, m_sz, m_wait;
    logic [31:0] m_data;
    bit          m_sticky;
    logic        e_req, e_stall, e_err, e_sticky;
    logic [31:0] e_rd;

    task automatic model_reset();
        m_pend = 0; m_done = 0; m_wr = 0; m_off = 0; m_sz = 0; m_wait = 0;
        m_data = 0; m_sticky = 0;
    endtask

    task automatic model_cycle();
        e_req = 0; e_stall = 0; e_err = 0; e_rd = 0; e_sticky = m_sticky;
        if (m_done) begin
            e_rd   = extract(m_data, m_off, m_sz);
            m_done = 0;
        end else if (m_pend == 0) begin
            if (MemReadM || MemWriteM) begin
                if (is_misaligned(SizeM, ALUResultM)) begin
                    e_err = 1;
                end else begin
                    e_req  = 1;
                    m_wr   = MemWriteM;
                    m_off  = ALUResultM % 4;
                    m_sz   = SizeM;
                    m_wait = 0;
                    if (!(m_wr && mem_gnt)) begin
                        e_stall = 1;
                        m_pend  = mem_gnt ? 2 : 1;
                    end
                end
            end
        end else if (m_pend == 1) begin
            e_req = 1; e_stall = 1;
            if (mem_gnt) begin
                if (m_wr) begin m_pend = 0; m_done = 1; end
                else begin m_pend = 2; m_wait = 0; end
            end else if (m_wait == TO - 1) begin
                e_err = 1; m_data = 0; m_pend = 0; m_done = 1;
            end else begin
                m_wait++;
            end
        end else begin
            e_stall = 1;
            if (mem_rvalid) begin
                m_data = mem_rdata; m_pend = 0; m_done = 1;
            end else if (m_wait == TO - 1) begin
                e_err = 1; m_data = 0; m_pend = 0; m_done = 1;
            end else begin
                m_wait++;
            end
        end
        m_sticky = m_sticky | e_err;
    endtask

    // ---------------- single-cycle vectors, all issued from idle and staying idle ----------------
    typedef struct packed {
        logic        rd;
        logic        wr;
        logic [1:0]  sz;
        logic [31:0] a;
        logic [31:0] wd;
        logic        gnt;
        logic        req;
        logic        stall;
        logic        err;
        logic [3:0]  be;
        logic [31:0] wdo;
    } vec_t;

    vec_t vecs[12];

    initial begin
        vecs[0]  = '{1'b0, 1'b1, 2'd2, 32'h104, 32'hDEAD_BEEF, 1'b1, 1'b1, 1'b0, 1'b0, 4'hF, 32'hDEAD_BEEF};
        vecs[1]  = '{1'b0, 1'b1, 2'd0, 32'h101, 32'h0000_00A5, 1'b1, 1'b1, 1'b0, 1'b0, 4'h2, 32'h0000_A500};
        vecs[2]  = '{1'b0, 1'b1, 2'd0, 32'h103, 32'h0000_005A, 1'b1, 1'b1, 1'b0, 1'b0, 4'h8, 32'h5A00_0000};
        vecs[3]  = '{1'b0, 1'b1, 2'd1, 32'h100, 32'h0000_BEEF, 1'b1, 1'b1, 1'b0, 1'b0, 4'h3, 32'h0000_BEEF};
        vecs[4]  = '{1'b0, 1'b1, 2'd1, 32'h102, 32'h0000_CAFE, 1'b1, 1'b1, 1'b0, 1'b0, 4'hC, 32'hCAFE_0000};
        vecs[5]  = '{1'b1, 1'b1, 2'd0, 32'h102, 32'h0000_0077, 1'b1, 1'b1, 1'b0, 1'b0, 4'h4, 32'h0077_0000};
        vecs[6]  = '{1'b0, 1'b0, 2'd2, 32'h200, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0};
        vecs[7]  = '{1'b1, 1'b0, 2'd2, 32'h101, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 32'h0};
        vecs[8]  = '{1'b0, 1'b1, 2'd1, 32'h103, 32'h0000_1111, 1'b1, 1'b0, 1'b0, 1'b1, 4'h0, 32'h0};
        vecs[9]  = '{1'b0, 1'b1, 2'd2, 32'h106, 32'h2222_2222, 1'b1, 1'b0, 1'b0, 1'b1, 4'h0, 32'h0};
        vecs[10] = '{1'b1, 1'b0, 2'd3, 32'h100, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 1'b1, 4'h0, 32'h0};
        vecs[11] = '{1'b1, 1'b0, 2'd1, 32'h105, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 32'h0};
    end

    int gnt_pct[3] = '{60, 25, 3};

    initial begin
        logic last_stall;
        int   r;
        clr_in();

        // Reset: outputs forced low even with an aligned load presented.
        set_acc(1, 0, 2'd2, 32'h100, 0);
        #2;
        check("rst_req", {31'b0, mem_req}, 0);
        check("rst_stall", {31'b0, StallM}, 0);
        check("rst_err", {31'b0, BusErrM}, 0);
        check("rst_rdata", ReadDataM, 0);
        check("rst_sticky", {31'b0, BusErrSticky}, 0);
        clr_in();
        step();
        reset = 0;
        step();

        // Vector table.
        for (int i = 0; i < 12; i++) begin
            set_acc(vecs[i].rd, vecs[i].wr, vecs[i].sz, vecs[i].a, vecs[i].wd);
            mem_gnt = vecs[i].gnt;
            #2;
            check($sformatf("vec%0d_req", i), {31'b0, mem_req}, {31'b0, vecs[i].req});
            check($sformatf("vec%0d_stall", i), {31'b0, StallM}, {31'b0, vecs[i].stall});
            check($sformatf("vec%0d_err", i), {31'b0, BusErrM}, {31'b0, vecs[i].err});
            check($sformatf("vec%0d_rdata", i), ReadDataM, 0);
            if (vecs[i].req) begin
                check($sformatf("vec%0d_be", i), {28'b0, mem_be}, {28'b0, vecs[i].be});
                check($sformatf("vec%0d_wdata", i), mem_wdata, vecs[i].wdo);
                check($sformatf("vec%0d_addr", i), mem_addr, vecs[i].a & 32'hFFFF_FFFC);
                check($sformatf("vec%0d_we", i), {31'b0, mem_we}, {31'b0, vecs[i].wr});
            end
            step();
        end
        clr_in();
        step();
        check("vec_sticky", {31'b0, BusErrSticky}, 1);

        // LBU 0x103: grant at once, read data two cycles later.
        set_acc(1, 0, 2'd0, 32'h103, 0);
        mem_gnt = 1;
        #2;
        check("lbu_req0", {31'b0, mem_req}, 1);
        check("lbu_be", {28'b0, mem_be}, 32'h8);
        check("lbu_stall0", {31'b0, StallM}, 1);
        step();
        mem_gnt = 0;
        #2;
        check("lbu_req1", {31'b0, mem_req}, 0);
        check("lbu_stall1", {31'b0, StallM}, 1);
        step();
        mem_rvalid = 1; mem_rdata = 32'hAABB_CCDD;
        #2;
        check("lbu_stall2", {31'b0, StallM}, 1);
        check("lbu_rd2", ReadDataM, 0);
        step();
        mem_rvalid = 0; mem_rdata = 0;
        #2;
        check("lbu_done_stall", {31'b0, StallM}, 0);
        check("lbu_done_rdata", ReadDataM, 32'h0000_00AA);
        step();
        clr_in();

        // SH 0x102 with the grant delayed to the third cycle.
        set_acc(0, 1, 2'd1, 32'h102, 32'h0000_1234);
        for (int c = 0; c < 3; c++) begin
            mem_gnt = (c == 2);
            #2;
            check($sformatf("sh_req%0d", c), {31'b0, mem_req}, 1);
            check($sformatf("sh_stall%0d", c), {31'b0, StallM}, 1);
            check($sformatf("sh_be%0d", c), {28'b0, mem_be}, 32'hC);
            check($sformatf("sh_wdata%0d", c), mem_wdata, 32'h1234_0000);
            check($sformatf("sh_we%0d", c), {31'b0, mem_we}, 1);
            step();
        end
        mem_gnt = 0;
        #2;
        check("sh_done_stall", {31'b0, StallM}, 0);
        check("sh_done_req", {31'b0, mem_req}, 0);
        step();
        clr_in();

        // Misaligned LW.
        set_acc(1, 0, 2'd2, 32'h101, 0);
        #2;
        check("mis_req", {31'b0, mem_req}, 0);
        check("mis_err", {31'b0, BusErrM}, 1);
        check("mis_stall", {31'b0, StallM}, 0);
        step();
        clr_in();
        #2;
        check("mis_err_pulse", {31'b0, BusErrM}, 0);
        check("mis_sticky", {31'b0, BusErrSticky}, 1);
        step();

        // LW never granted: error on the 16th wait cycle, late grant ignored.
        set_acc(1, 0, 2'd2, 32'h200, 0);
        #2;
        check("to_req0", {31'b0, mem_req}, 1);
        check("to_stall0", {31'b0, StallM}, 1);
        step();
        for (int k = 1; k <= TO; k++) begin
            #2;
            check($sformatf("to_stall_w%0d", k), {31'b0, StallM}, 1);
            check($sformatf("to_err_w%0d", k), {31'b0, BusErrM}, {31'b0, k == TO});
            step();
        end
        mem_gnt = 1;
        #2;
        check("to_done_stall", {31'b0, StallM}, 0);
        check("to_done_req", {31'b0, mem_req}, 0);
        check("to_done_rdata", ReadDataM, 0);
        step();
        MemReadM = 0;
        #2;
        check("to_late_req", {31'b0, mem_req}, 0);
        check("to_late_stall", {31'b0, StallM}, 0);
        step();
        clr_in();

        // Reset while waiting for read data.
        set_acc(1, 0, 2'd2, 32'h300, 0);
        mem_gnt = 1;
        step();
        mem_gnt = 0;
        reset = 1;
        #2;
        check("rwr_stall_in", {31'b0, StallM}, 0);
        check("rwr_req_in", {31'b0, mem_req}, 0);
        step();
        reset = 0;
        MemReadM = 0;
        mem_rvalid = 1; mem_rdata = 32'h1234_5678;
        #2;
        check("rwr_stall", {31'b0, StallM}, 0);
        check("rwr_sticky", {31'b0, BusErrSticky}, 0);
        check("rwr_rdata", ReadDataM, 0);
        step();
        mem_rvalid = 0;
        #2;
        check("rwr_stray_rdata", ReadDataM, 0);
        check("rwr_stray_stall", {31'b0, StallM}, 0);
        step();

        // Randomized run against the reference model.
        clr_in();
        reset = 1;
        step();
        reset = 0;
        model_reset();
        last_stall = 0;
        for (int p = 0; p < 3; p++) begin
            for (int n = 0; n < 1200; n++) begin
                if (!last_stall) begin
                    r = $urandom_range(0, 9);
                    if (r < 3) begin
                        set_acc(0, 0, 2'($urandom_range(0, 3)), $urandom, $urandom);
                    end else begin
                        r = $urandom_range(0, 2);
                        set_acc(r != 1, r != 0,
                                ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2)),
                                ($urandom_range(0, 9) < 7) ? ($urandom & 32'hFFFF_FFFC) : $urandom,
                                $urandom);
                    end
                end
                mem_gnt = ($urandom_range(0, 99) < gnt_pct[p]);
                if (m_pend == 2) mem_rvalid = ($urandom_range(0, 99) < gnt_pct[p]);
                else if (m_done) mem_rvalid = ($urandom_range(0, 3) == 0);
                else mem_rvalid = 0;
                mem_rdata = $urandom;
                #2;
                model_cycle();
                check("rnd_req", {31'b0, mem_req}, {31'b0, e_req});
                check("rnd_stall", {31'b0, StallM}, {31'b0, e_stall});
                check("rnd_err", {31'b0, BusErrM}, {31'b0, e_err});
                check("rnd_rdata", ReadDataM, e_rd);
                check("rnd_sticky", {31'b0, BusErrSticky}, {31'b0, e_sticky});
                if (e_req) begin
                    check("rnd_addr", mem_addr, ALUResultM & 32'hFFFF_FFFC);
                    check("rnd_be", {28'b0, mem_be}, (SizeM == 2) ? 32'hF :
                          (((SizeM == 0) ? 32'h1 : 32'h3) << (ALUResultM % 4)));
                    check("rnd_wdata", mem_wdata, WriteDataM << (8 * (ALUResultM % 4)));
                    check("rnd_we", {31'b0, mem_we}, {31'b0, m_wr});
                end
                last_stall = e_stall;
                step();
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
